// File: rtl/mssv_seq_ctrl_pkg.sv
// Shared types and constants for the ID-digit sequencer.
//   Sizing:  DEPTH program slots of DW-bit digits, AW-bit slot address,
//            LW-bit run length, CW-bit saturating hit counters.
//   Types:   state_e (controller FSM), wr_req_t (host digit write payload).
//   Helpers: sat_inc (saturating counter increment).
package mssv_seq_ctrl_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Detector done codes
  localparam logic [1:0] DONE_NONE = 2'b00;
  localparam logic [1:0] DONE_EVEN = 2'b01;
  localparam logic [1:0] DONE_ODD  = 2'b10;
  localparam logic [1:0] DONE_ILL  = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  // Increment that sticks at all-ones
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/mssv_seq_ctrl_if.sv
// Bundle of host and detector signals around the sequencer.
//   Host side:     wr_en/wr_addr/wr_data, len, start in; busy, done,
//                  even_cnt, odd_cnt, err out.
//   Detector side: digit_out, digit_vld, det_rst out; done_in in.
//   master: the environment (host + detector); slave: the controller.
interface mssv_seq_ctrl_if;
  import mssv_seq_ctrl_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [LW-1:0] len;
  logic          start;
  logic [DW-1:0] digit_out;
  logic          digit_vld;
  logic          det_rst;
  logic [1:0]    done_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] even_cnt;
  logic [CW-1:0] odd_cnt;
  logic          err;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, done_in,
    input  digit_out, digit_vld, det_rst, busy, done, even_cnt, odd_cnt, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, done_in,
    output digit_out, digit_vld, det_rst, busy, done, even_cnt, odd_cnt, err
  );

endinterface

// File: rtl/mssv_digit_buf.sv
// DEPTH x DW digit program buffer: one registered write port, one
// combinational read port, cleared by the async active-low reset.
//   clk, rst : clock, async active-low reset
//   we, wr   : write enable and {addr, data} payload
//   raddr    : read slot; rdata : slot contents
module mssv_digit_buf
  import mssv_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  wr_req_t       wr,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage with full clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr.addr] <= wr.data;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mssv_seq_ctrl.sv
// Plays a programmed string of ID digits into an external Mealy detector,
// one digit per clock, and tallies the detector's even/odd hit codes.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of mssv_seq_ctrl_if (host write/start port,
//              detector digit/reset/done-code port, status outputs)
module mssv_seq_ctrl
  import mssv_seq_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mssv_seq_ctrl_if.slave bus
);

  state_e        state;
  state_e        state_nx;
  logic [AW-1:0] idx;
  logic [LW-1:0] len_q;
  logic [CW-1:0] even_q;
  logic [CW-1:0] odd_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;
  logic          det_rst_q;
  logic          vld_q;
  logic [DW-1:0] rd_data;
  wr_req_t       wr_req;
  logic          wr_ok;
  logic          len_ok;
  logic          last;

  assign len_ok = (bus.len != '0) && (bus.len <= LW'(DEPTH));
  assign last   = (LW'(idx) == len_q - LW'(1));
  // Buffer is frozen while a run is playing
  assign wr_ok  = bus.wr_en && (state != RUN);
  assign wr_req = '{addr: bus.wr_addr, data: bus.wr_data};

  mssv_digit_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .wr    (wr_req),
    .raddr (idx),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start && len_ok) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run bookkeeping, hit counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      len_q     <= '0;
      even_q    <= '0;
      odd_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_rst_q <= 1'b1;
      vld_q     <= 1'b0;
    end else begin
      busy_q    <= (state_nx == RUN);
      vld_q     <= (state_nx == RUN);
      det_rst_q <= (state_nx != RUN);
      done_q    <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            even_q <= '0;
            odd_q  <= '0;
            if (len_ok) begin
              len_q <= bus.len;
              idx   <= '0;
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          case (bus.done_in)
            DONE_EVEN: even_q <= sat_inc(even_q);
            DONE_ODD:  odd_q  <= sat_inc(odd_q);
            DONE_ILL:  err_q  <= 1'b1;
            default:   ;
          endcase
          idx <= last ? '0 : idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.digit_out = vld_q ? rd_data : '0;
  assign bus.digit_vld = vld_q;
  assign bus.det_rst   = det_rst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.even_cnt  = even_q;
  assign bus.odd_cnt   = odd_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mssv_seq_ctrl.sv
// Bench for mssv_seq_ctrl: a behavioural ID detector (hit after the digits
// 0,6,0; parity of the following digit picks even/odd) sits on the digit
// port, with an override to inject fixed done codes. Expected counts come
// from scanning the bench's own copy of the program buffer.
module tb_mssv_seq_ctrl;
  import mssv_seq_ctrl_pkg::*;

  logic clk;
  logic rst;

  mssv_seq_ctrl_if bus ();

  mssv_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  logic [2:0] mem_m [DEPTH];
  logic       force_en;
  logic [1:0] force_code;

  // Detector: history of digits played since its reset was released
  logic [2:0] h0 = 3'd0, h1 = 3'd0, h2 = 3'd0;
  int         hn = 0;
  logic [1:0] det_code;

  always @(posedge clk or negedge rst) begin
    if (!rst || bus.det_rst) begin
      hn <= 0;
    end else begin
      h2 <= h1;
      h1 <= h0;
      h0 <= bus.digit_out;
      hn <= hn + 1;
    end
  end

  always_comb begin
    det_code = DONE_NONE;
    if (bus.digit_vld && hn >= 3 && h2 == 3'd0 && h1 == 3'd6 && h0 == 3'd0)
      det_code = bus.digit_out[0] ? DONE_ODD : DONE_EVEN;
  end

  assign bus.done_in = force_en ? force_code : det_code;

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected outcome of a run of n digits over the mirrored buffer
  function automatic void model(input int n, output int ev, output int od, output int er);
    ev = 0; od = 0; er = 0;
    if (force_en) begin
      case (force_code)
        2'b01:   ev = n;
        2'b10:   od = n;
        2'b11:   er = 1;
        default: ;
      endcase
    end else begin
      for (int k = 3; k < n; k++) begin
        if (mem_m[k-3] == 3'd0 && mem_m[k-2] == 3'd6 && mem_m[k-1] == 3'd0) begin
          if (mem_m[k][0]) od++;
          else             ev++;
        end
      end
    end
    if (ev > 15) ev = 15;
    if (od > 15) od = 15;
  endfunction

  function automatic int rnd_digit();
    int r;
    r = int'($urandom_range(0, 5));
    if (r < 3)  return 0;
    if (r == 3) return 6;
    return int'($urandom_range(0, 7));
  endfunction

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = 3'(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    mem_m[a]  = 3'(d);
  endtask

  task automatic load(input int q[$]);
    foreach (q[i]) wr(i, q[i]);
  endtask

  task automatic run(input string tag, input int n, input bit inject);
    int ev, od, er;
    model(n, ev, od, er);
    bus.start = 1'b1;
    bus.len   = LW'(n);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      ck({tag, ".busy"},  32'(bus.busy), 1);
      ck({tag, ".vld"},   32'(bus.digit_vld), 1);
      ck({tag, ".drst"},  32'(bus.det_rst), 0);
      ck({tag, ".done"},  32'(bus.done), 0);
      ck({tag, ".digit"}, 32'(bus.digit_out), 32'(mem_m[k]));
      if (inject && k == 1) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(2);
        bus.wr_data = ~mem_m[2];
        bus.start   = 1'b1;
        bus.len     = LW'(n);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    ck({tag, ".dn_done"}, 32'(bus.done), 1);
    ck({tag, ".dn_busy"}, 32'(bus.busy), 0);
    ck({tag, ".dn_drst"}, 32'(bus.det_rst), 1);
    ck({tag, ".dn_vld"},  32'(bus.digit_vld), 0);
    ck({tag, ".dn_dig"},  32'(bus.digit_out), 0);
    ck({tag, ".even"},    32'(bus.even_cnt), 32'(ev));
    ck({tag, ".odd"},     32'(bus.odd_cnt), 32'(od));
    ck({tag, ".err"},     32'(bus.err), 32'(er));
    @(negedge clk);
    ck({tag, ".id_done"}, 32'(bus.done), 0);
    ck({tag, ".id_busy"}, 32'(bus.busy), 0);
    ck({tag, ".id_drst"}, 32'(bus.det_rst), 1);
    ck({tag, ".id_even"}, 32'(bus.even_cnt), 32'(ev));
    ck({tag, ".id_odd"},  32'(bus.odd_cnt), 32'(od));
  endtask

  task automatic bad_start(input string tag, input int n);
    bus.start = 1'b1;
    bus.len   = LW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    ck({tag, ".err"},  32'(bus.err), 1);
    ck({tag, ".busy"}, 32'(bus.busy), 0);
    ck({tag, ".done"}, 32'(bus.done), 0);
    ck({tag, ".even"}, 32'(bus.even_cnt), 0);
    ck({tag, ".odd"},  32'(bus.odd_cnt), 0);
    ck({tag, ".drst"}, 32'(bus.det_rst), 1);
    @(negedge clk);
    ck({tag, ".busy2"}, 32'(bus.busy), 0);
    ck({tag, ".done2"}, 32'(bus.done), 0);
    ck({tag, ".err2"},  32'(bus.err), 1);
  endtask

  task automatic ck_reset_vals(input string tag);
    ck({tag, ".busy"},  32'(bus.busy), 0);
    ck({tag, ".done"},  32'(bus.done), 0);
    ck({tag, ".vld"},   32'(bus.digit_vld), 0);
    ck({tag, ".digit"}, 32'(bus.digit_out), 0);
    ck({tag, ".drst"},  32'(bus.det_rst), 1);
    ck({tag, ".even"},  32'(bus.even_cnt), 0);
    ck({tag, ".odd"},   32'(bus.odd_cnt), 0);
    ck({tag, ".err"},   32'(bus.err), 0);
  endtask

  initial begin
    int q[$];
    rst         = 1'b1;
    force_en    = 1'b0;
    force_code  = 2'b00;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.len     = '0;
    bus.start   = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 3'd0;

    #2 rst = 1'b0;
    #1 ck_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Buffer comes out of reset all zero
    run("rstbuf", 8, 1'b0);

    q = {0, 6, 0, 0};
    load(q);
    run("s1", 4, 1'b0);

    q = {0, 6, 0, 1};
    load(q);
    run("s2", 4, 1'b0);

    q = {0, 6, 0, 0, 0, 6, 0, 7};
    load(q);
    run("s3", 8, 1'b0);
    run("s3wrap", 8, 1'b0);

    bad_start("len0", 0);
    bad_start("len9", 9);
    bad_start("len15", 15);
    run("errclr", 4, 1'b0);

    // Write and start in the same IDLE cycle: write is visible to the run
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(3);
    bus.wr_data = 3'd1;
    mem_m[3]    = 3'd1;
    run("wrstart", 4, 1'b0);

    // Write and start during RUN are ignored
    run("inj", 4, 1'b1);
    run("inj_after", 4, 1'b0);

    force_en = 1'b1;
    force_code = 2'b11;
    run("ill", 3, 1'b0);
    force_code = 2'b01;
    run("fev", 5, 1'b0);
    force_code = 2'b10;
    run("fod", 6, 1'b0);
    force_en = 1'b0;

    // Reset in the middle of a run
    q = {0, 6, 0, 0};
    load(q);
    bus.start = 1'b1;
    bus.len   = LW'(4);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 ck_reset_vals("midrst");
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ck("midrst.nodone", 32'(bus.done), 0);
      ck("midrst.idle",   32'(bus.busy), 0);
    end
    run("postrst_zero", 4, 1'b0);
    load(q);
    run("postrst", 4, 1'b0);

    // Randomised programs and lengths
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        bad_start("rbad", ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15)));
      end else begin
        int nw;
        nw = int'($urandom_range(0, 8));
        for (int j = 0; j < nw; j++) wr(int'($urandom_range(0, 7)), rnd_digit());
        force_en   = ($urandom_range(0, 7) == 0);
        force_code = 2'($urandom_range(1, 3));
        run("rnd", int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
        force_en = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
